channel_pipelined_adds: RTL and testbench

- Single-channel arithmetic block that adds a fixed constant of 2 to each valid 16-bit input word.
- The addition is built as a chain of two +1 stages, and the sum is captured in an output register.
- Sits behind a valid-qualified data channel.
- `result` holds the last accepted sum until the next valid word arrives.

---
 rtl/channel_adds_pkg.sv | 25 ++
 rtl/add_stage.sv | 25 ++
 rtl/channel_pipelined_adds.sv | 79 +++++++
 tb/tb_channel_pipelined_adds.sv | 139 +++++++++++++
 4 files changed

// File: rtl/channel_adds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : channel_adds_pkg
// Purpose  : Shared defaults and types for the channel_pipelined_adds block.
//            Optional feature macro: CHANNEL_PIPELINED_ADDS_OUT_VALID_EN
//            (consumed by the top level, listed here for visibility).
// Contents : WIDTH, NUM_STAGES and STAGE_INC defaults, the word_t data type,
//            and a helper giving the total constant added by the chain.
// Revision : 1.0 - initial release
// ============================================================================
package channel_adds_pkg;

  localparam int WIDTH      = 16;
  localparam int NUM_STAGES = 2;
  localparam int STAGE_INC  = 1;

  typedef logic [WIDTH-1:0] word_t;

  // Total constant contributed by a chain of increment stages.
  function automatic int total_inc(input int stages, input int inc);
    return stages * inc;
  endfunction

endpackage : channel_adds_pkg
`default_nettype wire

// File: rtl/add_stage.sv
`default_nettype none
// ============================================================================
// Module   : add_stage
// Purpose  : One combinational increment stage: out = in + STAGE_INC,
//            modulo 2^WIDTH (carry out is dropped on purpose).
// Ports    : in_word  - input word
//            out_word - incremented word
// Revision : 1.0 - initial release
// ============================================================================
module add_stage
  import channel_adds_pkg::*;
#(
  parameter int WIDTH     = channel_adds_pkg::WIDTH,
  parameter int STAGE_INC = channel_adds_pkg::STAGE_INC
) (
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] out_word
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(STAGE_INC);

  assign out_word = in_word + INC_W;

endmodule : add_stage
`default_nettype wire

// File: rtl/channel_pipelined_adds.sv
`default_nettype none
// ============================================================================
// Module   : channel_pipelined_adds
// Purpose  : Adds NUM_STAGES*STAGE_INC (2 by default) to each valid input
//            word through a chain of combinational increment stages and
//            captures the sum in an output register. The register holds
//            the last accepted sum while the channel is idle.
// Macro    : CHANNEL_PIPELINED_ADDS_OUT_VALID_EN - adds a registered
//            out_valid port that pulses after each accepting edge.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset
//            in_valid  - channel valid, only bit 0 is used
//            in_data   - channel data word
//            result    - registered sum of the last accepted word
//            out_valid - (macro only) result was updated on the last edge
// Revision : 1.0 - initial release
// ============================================================================
module channel_pipelined_adds
  import channel_adds_pkg::*;
#(
  parameter int WIDTH      = channel_adds_pkg::WIDTH,
  parameter int NUM_STAGES = channel_adds_pkg::NUM_STAGES,
  parameter int STAGE_INC  = channel_adds_pkg::STAGE_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef CHANNEL_PIPELINED_ADDS_OUT_VALID_EN
  output logic             out_valid,
`endif
  output logic [WIDTH-1:0] result
);

  // chain[0] is the raw input, chain[NUM_STAGES] the fully incremented sum.
  logic [WIDTH-1:0] chain [0:NUM_STAGES];
  logic             accept;

  // Upper valid bits carry no meaning for this channel.
  logic unused_valid_hi;
  assign unused_valid_hi = ^in_valid[15:1];

  assign accept   = in_valid[0];
  assign chain[0] = in_data;

  generate
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
      add_stage #(
        .WIDTH     (WIDTH),
        .STAGE_INC (STAGE_INC)
      ) u_add_stage (
        .in_word  (chain[i]),
        .out_word (chain[i+1])
      );
    end
  endgenerate

  // Reset wins over valid; when idle the data input is never looked at,
  // so an undriven in_data cannot leak into result.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (accept) begin
      result <= chain[NUM_STAGES];
    end
  end

`ifdef CHANNEL_PIPELINED_ADDS_OUT_VALID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
    end
  end
`endif

endmodule : channel_pipelined_adds
`default_nettype wire

// File: tb/tb_channel_pipelined_adds.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_pipelined_adds
// Purpose  : Self-checking bench for channel_pipelined_adds using a table of
//            directed vectors plus hand-written sequences for the latency
//            and reset corner cases.
// Macro    : CHANNEL_PIPELINED_ADDS_OUT_VALID_EN - also checks out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_channel_pipelined_adds;
  import channel_adds_pkg::*;

  typedef struct {
    logic        rst;
    logic [15:0] valid;
    word_t       data;
    word_t       exp_result;
    logic        exp_ovalid;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] in_valid;
  word_t       in_data;
  word_t       result;
`ifdef CHANNEL_PIPELINED_ADDS_OUT_VALID_EN
  logic        out_valid;
`endif

  int total;
  int bad;

  channel_pipelined_adds dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef CHANNEL_PIPELINED_ADDS_OUT_VALID_EN
    .out_valid(out_valid),
`endif
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_result(input string name, input word_t exp);
    total++;
    if (result !== exp) begin
      bad++;
      $display("FAIL %s: result=%h expected=%h", name, result, exp);
    end
  endtask

  task automatic check_ovalid(input string name, input logic exp);
`ifdef CHANNEL_PIPELINED_ADDS_OUT_VALID_EN
    total++;
    if (out_valid !== exp) begin
      bad++;
      $display("FAIL %s: out_valid=%b expected=%b", name, out_valid, exp);
    end
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input logic r, input logic [15:0] v, input word_t d);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [14];

  initial begin
    rst      = 1'b1;
    in_valid = '0;
    in_data  = '0;
    total    = 0;
    bad      = 0;

    vecs[0]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // reset
    vecs[1]  = '{1'b0, 16'h0001, 16'd10,   16'd12,   1'b1}; // single accept
    vecs[2]  = '{1'b0, 16'h0001, 16'd15,   16'd17,   1'b1}; // back-to-back
    vecs[3]  = '{1'b0, 16'h0000, 16'd18,   16'd17,   1'b0}; // hold
    vecs[4]  = '{1'b0, 16'h0000, 16'h1234, 16'd17,   1'b0}; // idle
    vecs[5]  = '{1'b0, 16'h0000, 16'hxxxx, 16'd17,   1'b0}; // idle with X data
    vecs[6]  = '{1'b0, 16'h0000, 16'hFFFF, 16'd17,   1'b0}; // idle
    vecs[7]  = '{1'b0, 16'h0001, 16'hFFFF, 16'h0001, 1'b1}; // wrap
    vecs[8]  = '{1'b1, 16'h0001, 16'd5,    16'h0000, 1'b0}; // reset beats valid
    vecs[9]  = '{1'b0, 16'h0001, 16'd5,    16'd7,    1'b1}; // first after reset
    vecs[10] = '{1'b0, 16'h0002, 16'd7,    16'd7,    1'b0}; // upper bit only
    vecs[11] = '{1'b0, 16'hFFFF, 16'hFFFE, 16'h0000, 1'b1}; // all bits, wrap to 0
    vecs[12] = '{1'b0, 16'hFFFE, 16'h0100, 16'h0000, 1'b0}; // all but bit 0
    vecs[13] = '{1'b0, 16'h8001, 16'hFFFD, 16'hFFFF, 1'b1}; // max without wrap

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].rst, vecs[i].valid, vecs[i].data);
      check_result($sformatf("vec%0d", i), vecs[i].exp_result);
      check_ovalid($sformatf("vec%0d_ov", i), vecs[i].exp_ovalid);
    end

    // Latency: new input must not be visible before the accepting edge.
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 16'h0001;
    in_data  = 16'd100;
    #2;
    check_result("no_comb_path", 16'hFFFF);
    @(posedge clk);
    #1;
    check_result("lat_one_edge", 16'd102);
    check_ovalid("lat_one_edge_ov", 1'b1);

    // Burst of accepts, then a reset in the middle, then resume.
    step(1'b0, 16'h0001, 16'd200);
    check_result("burst_a", 16'd202);
    step(1'b0, 16'h0001, 16'd300);
    check_result("burst_b", 16'd302);
    step(1'b1, 16'h0001, 16'd400);
    check_result("burst_rst", 16'd0);
    check_ovalid("burst_rst_ov", 1'b0);
    step(1'b0, 16'h0000, 16'd500);
    check_result("post_rst_idle", 16'd0);
    check_ovalid("post_rst_idle_ov", 1'b0);
    step(1'b0, 16'h0001, 16'd500);
    check_result("post_rst_accept", 16'd502);
    check_ovalid("post_rst_accept_ov", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_channel_pipelined_adds
`default_nettype wire
